rr_arb_mux: RTL

//   N-input, WIDTH-bit registered selector with valid/ready handshake on every port.

---
 rtl/rr_arb_mux_if.sv | 20 ++
 rtl/rr_arb_mux.sv | 51 +++++
 2 files changed

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: producer/consumer bundle for rr_arb_mux (select, N input channels, one registered output)
//   mode/sel              arbitration mode and explicit channel index
//   in_valid/in_data/in_ready   per-channel handshake, channel i at in_data[i*WIDTH +: WIDTH]
//   out_valid/out_data/out_src/out_ready   registered output handshake
interface rr_arb_mux_if #(parameter int WIDTH = 32, parameter int N = 4);
   localparam int SELW = $clog2(N);
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [N-1:0]         in_valid;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_src;
   logic                 out_ready;
   modport master (output mode, sel, in_valid, in_data, out_ready,
                   input in_ready, out_valid, out_data, out_src);
   modport slave (input mode, sel, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_src);
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input registered selector, explicit-select or round-robin, valid/ready on every port
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        rr_arb_mux_if slave: mode/sel, in_valid/in_data/in_ready, out_valid/out_data/out_src/out_ready
module rr_arb_mux #(parameter int WIDTH = 32, parameter int N = 4) (
   input logic clk,
   input logic rst,
   rr_arb_mux_if.slave bus
);
   localparam int SELW = $clog2(N);
   logic [SELW-1:0]  ptr, gnt, idx;
   logic             gnt_v, ld;
   logic [WIDTH-1:0] gnt_data;
   assign ld = ~bus.out_valid | bus.out_ready;
   always_comb begin
      gnt = bus.sel;
      gnt_v = 1'b0;
      idx = '0;
      gnt_data = '0;
      bus.in_ready = '0;
      // descending scan so the channel nearest after ptr is the last (winning) assignment
      for (int k = N; k >= 1; k--) begin
         idx = SELW'((int'(ptr) + k) % N);
         if (bus.mode && bus.in_valid[idx]) begin
            gnt = idx;
            gnt_v = 1'b1;
         end
      end
      // an out-of-range sel matches no channel and so never grants
      for (int i = 0; i < N; i++)
         if (!bus.mode && bus.sel == SELW'(i)) gnt_v = bus.in_valid[i];
      // only the granted channel reaches the register, so X on others cannot leak
      for (int i = 0; i < N; i++) begin
         if (gnt == SELW'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
         bus.in_ready[i] = ~rst & ld & gnt_v & (gnt == SELW'(i));
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_src <= '0;
         ptr <= SELW'(N - 1);
      end else if (ld) begin
         bus.out_valid <= gnt_v;
         if (gnt_v) begin
            bus.out_data <= gnt_data;
            bus.out_src <= gnt;
            ptr <= gnt;
         end
      end
endmodule
